// File: rtl/morse_display_ctrl.sv
// morse_display_ctrl
//
// Eight-digit scrolling character buffer for the seven-segment display
// driver. Decoded Morse characters arrive over a valid/ready handshake and
// enter at the rightmost digit (digit 0). Clear and backspace commands come
// from the button logic. After each accepted character, new characters are
// refused for HOLD_CYCLES cycles so the scrolling stays readable.
//
// Each digit is 6 bits, {en, num[3:0], dp}. An all-zero digit is blank.
//
// Optional feature macro: MORSE_BLINK_EN
//   When it is defined, the dp of digit 0 blinks with a half-period of
//   BLINK_CYCLES while the buffer holds at least one character. This marks
//   the newest character. The stored buffer is not changed by the blink.
//   When it is not defined, no blink logic is built and digits mirrors the
//   stored buffer exactly.

module morse_display_ctrl #(
    parameter int HOLD_CYCLES  = 1_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [3:0]  char_code,
    input  logic        char_dp,
    output logic        char_ready,
    input  logic        clr_req,
    input  logic        bksp_req,
    output logic [47:0] digits,
    output logic [3:0]  count,
    output logic        busy
);

    // The hold counter needs at least one bit. With HOLD_CYCLES = 0 the
    // HOLD state is never entered.
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    // Reject parameter values the counters cannot represent.
    if (HOLD_CYCLES < 0 || BLINK_CYCLES < 1) begin : g_bad_params
        $error("morse_display_ctrl: HOLD_CYCLES must be >= 0 and BLINK_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // These are the buffer operations that the sequencer requests for the
    // next edge.
    typedef enum logic [2:0] {
        OP_NONE      = 3'd0,
        OP_PUSH      = 3'd1,   // shift left, insert the new character at digit 0
        OP_BKSP      = 3'd2,   // shift right, blank digit 7
        OP_START_CLR = 3'd3,   // arm the wipe sequence at index 0
        OP_WIPE      = 3'd4    // blank digit[wipe_idx], advance the index
    } op_t;

    state_t            state_q, state_d;
    op_t               buf_op;
    logic [7:0][5:0]   buf_q;        // buf_q[k] is digit k
    logic [3:0]        count_q;
    logic [2:0]        wipe_idx_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              accept;

    // The handshake is offered only in IDLE when no command competes. Reset
    // also masks it, so a character presented during reset is not lost.
    assign char_ready = (state_q == ST_IDLE) & ~clr_req & ~bksp_req & ~reset;
    assign accept     = char_valid & char_ready;
    assign busy       = (state_q != ST_IDLE);
    assign count      = count_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written only with non-blocking
        // assignments. Every flop then samples the values from before the
        // edge, whatever order the processes run in.
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and selection of the buffer operation. Command
    // priority in IDLE is clear, then backspace, then character.
    always_comb begin
        // NOTE: every output of this block gets a default first. Any path
        // that does not assign one then keeps the default and cannot infer
        // a latch.
        state_d = state_q;
        buf_op  = OP_NONE;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    buf_op  = OP_START_CLR;
                end else if (bksp_req) begin
                    buf_op = OP_BKSP;
                end else if (accept) begin
                    buf_op = OP_PUSH;
                    if (HOLD_CYCLES > 0) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_CLEAR: begin
                // Requests are ignored here, and they are not queued.
                buf_op = OP_WIPE;
                if (wipe_idx_q == 3'd7) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // A clear aborts the hold. A backspace is ignored.
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    buf_op  = OP_START_CLR;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Hold counter. It runs only while the FSM stays in HOLD, so it is 0 on
    // entry to HOLD and again after leaving it.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else if (state_q == ST_HOLD && state_d == ST_HOLD) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end else begin
            hold_cnt_q <= '0;
        end
    end

    // Character buffer, character count and wipe index.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is a small bank of flops, not a RAM. It is reset
        // on purpose so the display comes up blank rather than showing junk.
        if (reset) begin
            buf_q      <= '0;
            count_q    <= '0;
            wipe_idx_q <= '0;
        end else begin
            unique case (buf_op)
                OP_PUSH: begin
                    for (int k = 7; k > 0; k--) begin
                        buf_q[k] <= buf_q[k-1];
                    end
                    buf_q[0] <= {1'b1, char_code, char_dp};
                    if (count_q != 4'd8) begin
                        count_q <= count_q + 4'd1;
                    end
                end
                OP_BKSP: begin
                    // At count 0 the shift still happens. It is harmless
                    // because every digit is already blank.
                    for (int k = 0; k < 7; k++) begin
                        buf_q[k] <= buf_q[k+1];
                    end
                    buf_q[7] <= 6'b0;
                    if (count_q != 4'd0) begin
                        count_q <= count_q - 4'd1;
                    end
                end
                OP_START_CLR: begin
                    wipe_idx_q <= 3'd0;
                end
                OP_WIPE: begin
                    buf_q[wipe_idx_q] <= 6'b0;
                    wipe_idx_q        <= wipe_idx_q + 3'd1;
                    if (wipe_idx_q == 3'd7) begin
                        count_q <= 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MORSE_BLINK_EN
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_q;

    // Free-running blink timer. The flag toggles once every BLINK_CYCLES
    // cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // Display view. The blink flag is ORed into the dp of the newest digit
    // only. The stored buffer is left unchanged.
    always_comb begin
        digits    = buf_q;
        digits[0] = buf_q[0][0] | (blink_q & (count_q != 4'd0));
    end
`else
    assign digits = buf_q;
`endif

endmodule

// File: tb/tb_morse_display_ctrl.sv
// Bench for morse_display_ctrl.
// The stimulus process drives the inputs a little after each rising edge and
// pushes the response it expects for that cycle into a scoreboard queue. A
// separate monitor samples both DUTs on the falling edge, pops the entries
// due in that cycle and compares them.
// dut_a runs with HOLD_CYCLES=2 and dut_b with HOLD_CYCLES=0. Both use
// BLINK_CYCLES=4, which only matters when MORSE_BLINK_EN is defined.

module tb_morse_display_ctrl;

    localparam int A_HOLD  = 2;
    localparam int B_BLINK = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_reset, a_valid, a_dp, a_clr, a_bksp, a_ready, a_busy;
    logic [3:0]  a_code, a_count;
    logic [47:0] a_digits;
    logic        b_reset, b_valid, b_dp, b_clr, b_bksp, b_ready, b_busy;
    logic [3:0]  b_code, b_count;
    logic [47:0] b_digits;

    morse_display_ctrl #(.HOLD_CYCLES(A_HOLD), .BLINK_CYCLES(B_BLINK)) dut_a (
        .clk(clk), .reset(a_reset), .char_valid(a_valid), .char_code(a_code),
        .char_dp(a_dp), .char_ready(a_ready), .clr_req(a_clr), .bksp_req(a_bksp),
        .digits(a_digits), .count(a_count), .busy(a_busy)
    );

    morse_display_ctrl #(.HOLD_CYCLES(0), .BLINK_CYCLES(B_BLINK)) dut_b (
        .clk(clk), .reset(b_reset), .char_valid(b_valid), .char_code(b_code),
        .char_dp(b_dp), .char_ready(b_ready), .clr_req(b_clr), .bksp_req(b_bksp),
        .digits(b_digits), .count(b_count), .busy(b_busy)
    );

    typedef struct {
        int          cyc;
        bit          sel;    // 0: dut_a, 1: dut_b
        string       name;
        logic [47:0] dig;
        logic [3:0]  cnt;
        logic        busy;
        logic        rdy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // These are the reference buffer contents and counts kept by the
    // stimulus.
    logic [47:0] a_model, b_model;
    int          a_cnt, b_cnt;
    int          a_rel, b_rel;   // first cycle after each DUT's reset is released

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares every scoreboard entry due in the current cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                total++;
                bad++;
                $display("FAIL %s: entry for cyc %0d reached at cyc %0d", e.name, e.cyc, cyc);
            end else begin
                check({e.name, "/digits"}, e.sel ? b_digits : a_digits, e.dig);
                check({e.name, "/count"}, 48'(e.sel ? b_count : a_count), 48'(e.cnt));
                check({e.name, "/busy"}, 48'(e.sel ? b_busy : a_busy), 48'(e.busy));
                check({e.name, "/ready"}, 48'(e.sel ? b_ready : a_ready), 48'(e.rdy));
            end
        end
    end

    // Display view expected for a stored buffer. When blinking is enabled,
    // the dp of digit 0 is high in every other block of B_BLINK cycles
    // after reset while count > 0.
    function automatic logic [47:0] shown(input bit sel, input logic [47:0] d, input int cnt);
        logic [47:0] r = d;
        int p = cyc - (sel ? b_rel : a_rel);
`ifdef MORSE_BLINK_EN
        if (cnt > 0 && ((p / B_BLINK) % 2) == 1) r[0] = 1'b1;
`else
        if (p < 0) r = d;
`endif
        return r;
    endfunction

    task automatic push(input bit sel, input string name, input logic [47:0] d,
                        input int cnt, input logic busy, input logic rdy);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.name = name;
        e.dig  = shown(sel, d, cnt);
        e.cnt  = 4'(cnt);
        e.busy = busy;
        e.rdy  = rdy;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one character to dut_a (idle), then ride out its hold.
    task automatic a_char(input logic [3:0] code, input logic dp);
        a_valid = 1'b1; a_code = code; a_dp = dp;
        push(0, "a_accept", a_model, a_cnt, 1'b0, 1'b1);
        step();
        a_valid = 1'b0;
        a_model = {a_model[41:0], 1'b1, code, dp};
        if (a_cnt < 8) a_cnt++;
        for (int h = 0; h < A_HOLD; h++) begin
            push(0, "a_hold", a_model, a_cnt, 1'b1, 1'b0);
            step();
        end
    endtask

    // dut_a is in CLEAR with the wipe index at 'from'. Run it up to 'upto'.
    task automatic a_wipe(input int from, input int upto);
        for (int k = from; k < upto; k++) begin
            push(0, "a_clear", a_model, a_cnt, 1'b1, 1'b0);
            step();
            a_model[6*k +: 6] = 6'b0;
        end
        if (upto == 8) a_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_reset = 1'b1; a_valid = 1'b0; a_code = 4'd0; a_dp = 1'b0; a_clr = 1'b0; a_bksp = 1'b0;
        b_reset = 1'b1; b_valid = 1'b0; b_code = 4'd0; b_dp = 1'b0; b_clr = 1'b0; b_bksp = 1'b0;
        a_model = '0; b_model = '0; a_cnt = 0; b_cnt = 0; a_rel = 0; b_rel = 0;

        // Reset values. char_ready must be low while reset is high.
        step();
        push(0, "a_reset", 48'b0, 0, 1'b0, 1'b0);
        push(1, "b_reset", 48'b0, 0, 1'b0, 1'b0);
        step();
        a_reset = 1'b0; b_reset = 1'b0; a_rel = cyc; b_rel = cyc;
        push(0, "a_post_reset", 48'b0, 0, 1'b0, 1'b1);
        push(1, "b_post_reset", 48'b0, 0, 1'b0, 1'b1);
        step();

        // Three characters with a 2-cycle hold.
        a_char(4'd1, 1'b0);
        a_char(4'd2, 1'b0);
        a_char(4'd3, 1'b0);
        push(0, "a_three", {30'b0, 6'h22, 6'h24, 6'h26}, 3, 1'b0, 1'b1);
        step();

        // Four backspaces: count goes 3,2,1,0,0.
        for (int i = 0; i < 4; i++) begin
            a_bksp = 1'b1;
            push(0, "a_bksp", a_model, a_cnt, 1'b0, 1'b0);
            step();
            a_model = {6'b0, a_model[47:6]};
            if (a_cnt > 0) a_cnt--;
        end
        a_bksp = 1'b0;
        push(0, "a_bksp_empty", 48'b0, 0, 1'b0, 1'b1);
        step();

        // Fill the buffer, then clear with a character offered in the same cycle.
        for (int i = 1; i <= 8; i++) a_char(4'(i), 1'(i % 2));
        a_clr = 1'b1; a_valid = 1'b1; a_code = 4'd5; a_dp = 1'b1;
        push(0, "a_clr_and_char", a_model, 8, 1'b0, 1'b0);
        step();
        a_clr = 1'b0;
        a_wipe(0, 8);
        push(0, "a_clr_done", 48'b0, 0, 1'b0, 1'b1);
        step();
        a_valid = 1'b0;
        a_model = {42'b0, 6'h2B};
        a_cnt = 1;
        for (int h = 0; h < A_HOLD; h++) begin
            push(0, "a_late_char", a_model, 1, 1'b1, 1'b0);
            step();
        end

        // During HOLD a backspace is ignored and a clear aborts the hold.
        a_valid = 1'b1; a_code = 4'd7; a_dp = 1'b0;
        push(0, "a_accept2", a_model, 1, 1'b0, 1'b1);
        step();
        a_valid = 1'b0; a_bksp = 1'b1;
        a_model = {a_model[41:0], 6'h2E};
        a_cnt = 2;
        push(0, "a_hold_bksp", a_model, 2, 1'b1, 1'b0);
        step();
        a_bksp = 1'b0; a_clr = 1'b1;
        push(0, "a_hold_clr", a_model, 2, 1'b1, 1'b0);
        step();
        a_clr = 1'b0;
        a_wipe(0, 8);
        push(0, "a_idle_after_abort", 48'b0, 0, 1'b0, 1'b1);
        step();

        // Reset asserted in CLEAR at wipe index 4.
        for (int i = 0; i < 8; i++) a_char(4'(i + 8), 1'b0);
        a_clr = 1'b1;
        push(0, "a_clr2", a_model, 8, 1'b0, 1'b0);
        step();
        a_clr = 1'b0;
        a_wipe(0, 4);
        push(0, "a_clear_idx4", a_model, 8, 1'b1, 1'b0);
        a_reset = 1'b1;
        step();
        a_model = '0; a_cnt = 0;
        push(0, "a_rst_mid", 48'b0, 0, 1'b0, 1'b0);
        step();
        a_reset = 1'b0; a_rel = cyc;
        push(0, "a_rst_release", 48'b0, 0, 1'b0, 1'b1);
        step();

        // No hold: ten back-to-back characters scroll one per cycle.
        for (int i = 0; i < 10; i++) begin
            b_valid = 1'b1; b_code = 4'(i); b_dp = 1'b0;
            push(1, "b_scroll", b_model, b_cnt, 1'b0, 1'b1);
            step();
            b_model = {b_model[41:0], 1'b1, 4'(i), 1'b0};
            if (b_cnt < 8) b_cnt++;
        end
        b_valid = 1'b0;
        push(1, "b_scroll_final",
             {6'h24, 6'h26, 6'h28, 6'h2A, 6'h2C, 6'h2E, 6'h30, 6'h32}, 8, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 9; i++) begin
            push(1, "b_idle_full", b_model, 8, 1'b0, 1'b1);
            step();
        end

        // Clear and backspace together: clear only, no shift.
        b_clr = 1'b1; b_bksp = 1'b1;
        push(1, "b_clr_bksp", b_model, 8, 1'b0, 1'b0);
        step();
        b_clr = 1'b0; b_bksp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            push(1, "b_clear", b_model, 8, 1'b1, 1'b0);
            step();
            b_model[6*k +: 6] = 6'b0;
        end
        b_cnt = 0;
        push(1, "b_cleared", 48'b0, 0, 1'b0, 1'b1);
        step();

        // A single character with dp=0. Digit 0's dp blinks only if enabled.
        b_valid = 1'b1; b_code = 4'hA; b_dp = 1'b0;
        push(1, "b_one_accept", 48'b0, 0, 1'b0, 1'b1);
        step();
        b_valid = 1'b0;
        b_model = {42'b0, 6'h34};
        b_cnt = 1;
        for (int i = 0; i < 10; i++) begin
            push(1, "b_one_view", b_model, 1, 1'b0, 1'b1);
            step();
        end

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
